// File: rtl/alu_pkg.sv
// Shared types for the EX-stage ALU: op classes, decoded functions, mul/div FSM states.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD   = 2'b00,
    OP_SUB   = 2'b01,
    OP_RTYPE = 2'b10,
    OP_ITYPE = 2'b11
  } alu_op_e;

  typedef enum logic [4:0] {
    FN_ADD, FN_SUB, FN_SLL, FN_SLT, FN_SLTU, FN_XOR, FN_SRL, FN_SRA,
    FN_OR, FN_AND, FN_MUL, FN_DIV, FN_DIVU, FN_REM, FN_REMU, FN_ILLEGAL
  } alu_fn_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} muldiv_state_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic logic is_divrem(alu_fn_e fn);
    return fn inside {FN_DIV, FN_DIVU, FN_REM, FN_REMU};
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative M-extension engine: 1 bit/cycle shift-add multiply, restoring divide on magnitudes.
module alu_muldiv_iter import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            start_i,
  input  alu_fn_e         fn_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] res_o
);
  localparam int CW = $clog2(XLEN);

  logic            busy_q, qneg_q, rneg_q;
  logic [CW-1:0]   cnt_q;
  alu_fn_e         fn_q;
  logic [XLEN-1:0] acc_q, x_q, y_q, acc_d, x_d, y_d;
  logic [XLEN:0]   rsh, rsub;
  logic            sdiv;

  function automatic logic [XLEN-1:0] mag(logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  assign sdiv = (fn_i == FN_DIV) || (fn_i == FN_REM);

  // MUL: acc=product, x=multiplier, y=multiplicand. DIV: acc=partial remainder, x=dividend->quotient, y=divisor.
  always_comb begin
    rsh   = {acc_q, x_q[XLEN-1]};
    rsub  = rsh - {1'b0, y_q};
    acc_d = acc_q;
    x_d   = x_q;
    y_d   = y_q;
    if (fn_q == FN_MUL) begin
      if (x_q[0]) acc_d = acc_q + y_q;
      x_d = x_q >> 1;
      y_d = y_q << 1;
    end else if (!rsub[XLEN]) begin
      acc_d = rsub[XLEN-1:0];
      x_d   = {x_q[XLEN-2:0], 1'b1};
    end else begin
      acc_d = rsh[XLEN-1:0];
      x_d   = {x_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      busy_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      cnt_q  <= '0;
      fn_q   <= FN_ADD;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (start_i) begin
      fn_q   <= fn_i;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
      if (fn_i == FN_MUL) begin
        x_q    <= b_i;
        y_q    <= a_i;
        qneg_q <= 1'b0;
        rneg_q <= 1'b0;
      end else begin
        x_q    <= sdiv ? mag(a_i) : a_i;
        y_q    <= sdiv ? mag(b_i) : b_i;
        qneg_q <= sdiv && (a_i[XLEN-1] ^ b_i[XLEN-1]);
        rneg_q <= sdiv && a_i[XLEN-1];
      end
    end else if (busy_q) begin
      acc_q <= acc_d;
      x_q   <= x_d;
      y_q   <= y_d;
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(XLEN-1)) busy_q <= 1'b0;
    end
  end

  // Flags the cycle whose edge performs the final iteration.
  assign done_o = busy_q && (cnt_q == CW'(XLEN-1));

  always_comb begin
    case (fn_q)
      FN_DIV, FN_DIVU: res_o = qneg_q ? -x_q : x_q;
      FN_REM, FN_REMU: res_o = rneg_q ? -acc_q : acc_q;
      default:         res_o = acc_q;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decode, single-cycle base ops, and handshake/FSM around the iterative mul/div engine.
module alu_exec_unit import alu_pkg::*; #(
  parameter int XLEN      = 32,
  parameter bit EN_MULDIV = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [1:0]      alu_op_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o,
  output logic            illegal_o
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic alu_fn_e decode(alu_op_e op, logic [2:0] f3, logic [6:0] f7);
    alu_fn_e fn;
    fn = FN_ILLEGAL;
    case (op)
      OP_ADD: fn = FN_ADD;
      OP_SUB: fn = FN_SUB;
      OP_RTYPE: begin
        if (f7 == F7_BASE) begin
          case (f3)
            3'd0: fn = FN_ADD;  3'd1: fn = FN_SLL;
            3'd2: fn = FN_SLT;  3'd3: fn = FN_SLTU;
            3'd4: fn = FN_XOR;  3'd5: fn = FN_SRL;
            3'd6: fn = FN_OR;   3'd7: fn = FN_AND;
          endcase
        end else if (f7 == F7_ALT) begin
          fn = (f3 == 3'd0) ? FN_SUB : (f3 == 3'd5) ? FN_SRA : FN_ILLEGAL;
        end else if (f7 == F7_MULDIV && EN_MULDIV) begin
          case (f3)
            3'd0:    fn = FN_MUL;
            3'd4:    fn = FN_DIV;
            3'd5:    fn = FN_DIVU;
            3'd6:    fn = FN_REM;
            3'd7:    fn = FN_REMU;
            default: fn = FN_ILLEGAL;
          endcase
        end
      end
      default: begin
        case (f3)
          3'd0: fn = FN_ADD;
          3'd1: fn = f7[5] ? FN_ILLEGAL : FN_SLL;
          3'd2: fn = FN_SLT;
          3'd3: fn = FN_SLTU;
          3'd4: fn = FN_XOR;
          3'd5: fn = f7[5] ? FN_SRA : FN_SRL;
          3'd6: fn = FN_OR;
          3'd7: fn = FN_AND;
        endcase
      end
    endcase
    return fn;
  endfunction

  alu_fn_e         fn;
  muldiv_state_e   state_q;
  logic            out_valid_q, zero_q, illegal_q;
  logic [XLEN-1:0] result_q, res_d, md_res;
  logic [SHW-1:0]  shamt;
  logic            special, go_busy, accept, md_done;

  assign fn    = decode(alu_op_e'(alu_op_i), funct3_i, funct7_i);
  assign shamt = op_b_i[SHW-1:0];

  // Divide-by-zero and signed overflow have closed-form answers, so they never enter BUSY.
  assign special = is_divrem(fn) && ((op_b_i == '0) ||
                   ((fn == FN_DIV || fn == FN_REM) && op_a_i == MIN_NEG && op_b_i == '1));
  assign go_busy = EN_MULDIV && ((fn == FN_MUL) || (is_divrem(fn) && !special));

  always_comb begin
    res_d = '0;
    case (fn)
      FN_ADD:          res_d = op_a_i + op_b_i;
      FN_SUB:          res_d = op_a_i - op_b_i;
      FN_SLL:          res_d = op_a_i << shamt;
      FN_SLT:          res_d = XLEN'($signed(op_a_i) < $signed(op_b_i));
      FN_SLTU:         res_d = XLEN'(op_a_i < op_b_i);
      FN_XOR:          res_d = op_a_i ^ op_b_i;
      FN_SRL:          res_d = op_a_i >> shamt;
      FN_SRA:          res_d = XLEN'($signed(op_a_i) >>> shamt);
      FN_OR:           res_d = op_a_i | op_b_i;
      FN_AND:          res_d = op_a_i & op_b_i;
      FN_DIV, FN_DIVU: res_d = (op_b_i == '0) ? '1 : op_a_i;
      FN_REM, FN_REMU: res_d = (op_b_i == '0) ? op_a_i : '0;
      default:         res_d = '0;
    endcase
  end

  assign in_ready_o = !rst_i && (state_q == IDLE) && (!out_valid_q || out_ready_i);
  assign accept     = in_valid_i && in_ready_o;

  generate
    if (EN_MULDIV) begin : g_md
      alu_muldiv_iter #(.XLEN(XLEN)) u_md (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .start_i (accept && go_busy && !flush_i),
        .fn_i    (fn),
        .a_i     (op_a_i),
        .b_i     (op_b_i),
        .done_o  (md_done),
        .res_o   (md_res)
      );
    end else begin : g_nomd
      assign md_done = 1'b0;
      assign md_res  = '0;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (out_valid_q && out_ready_i) out_valid_q <= 1'b0;
          if (accept) begin
            if (go_busy) begin
              state_q <= BUSY;
            end else begin
              out_valid_q <= 1'b1;
              result_q    <= res_d;
              zero_q      <= (res_d == '0);
              illegal_q   <= (fn == FN_ILLEGAL);
            end
          end
        end
        BUSY: if (md_done) state_q <= DONE;
        DONE: begin
          out_valid_q <= 1'b1;
          result_q    <= md_res;
          zero_q      <= (md_res == '0);
          illegal_q   <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (XLEN=32, M-ext enabled) with hand-computed expectations.
module tb_alu_exec_unit;
  localparam int XLEN = 32;
  localparam logic [1:0] OPA = 2'b00, OPB = 2'b01, R = 2'b10, I = 2'b11;
  localparam logic [6:0] F7B = 7'h00, F7A = 7'h20, F7M = 7'h01;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [1:0] alu_op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [XLEN-1:0] a, b, result;
  int checks = 0, errors = 0;

  alu_exec_unit #(.XLEN(XLEN), .EN_MULDIV(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_op_i(alu_op), .funct3_i(f3), .funct7_i(f7), .op_a_i(a), .op_b_i(b),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
    .zero_o(zero), .illegal_o(illegal)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [2:0] fn3, input logic [6:0] fn7,
                       input logic [XLEN-1:0] va, input logic [XLEN-1:0] vb);
    alu_op = op; f3 = fn3; f7 = fn7; a = va; b = vb; in_valid = 1'b1;
  endtask

  // Issues one op and waits (bounded) for its result; lat counts edges including the accepting one.
  task automatic run(input string tag, input logic [1:0] op, input logic [2:0] fn3,
                     input logic [6:0] fn7, input logic [XLEN-1:0] va, input logic [XLEN-1:0] vb,
                     input logic [XLEN-1:0] exp, input int lat, input logic ill);
    int k;
    logic stall_ok;
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    drive(op, fn3, fn7, va, vb);
    tick();
    in_valid = 1'b0;
    k = 1;
    stall_ok = 1'b1;
    while (!out_valid && k < 60) begin
      if (in_ready) stall_ok = 1'b0;
      tick();
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'(lat));
    chk({tag, " result"}, 64'(result), 64'(exp));
    chk({tag, " zero"}, 64'(zero), 64'(exp == '0));
    chk({tag, " illegal"}, 64'(illegal), 64'(ill));
    chk({tag, " stall"}, 64'(stall_ok), 64'd1);
  endtask

  initial begin
    logic ok, seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = '0; f3 = '0; f7 = '0; a = '0; b = '0;
    tick(); tick();
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    chk("rst zero", 64'(zero), 64'd0);
    chk("rst illegal", 64'(illegal), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0; #1;
    chk("post rst in_ready", 64'(in_ready), 64'd1);

    // back-to-back ADD / SUB
    drive(R, 3'd0, F7B, 32'd7, 32'hFFFF_FFFD);
    tick();
    chk("add valid", 64'(out_valid), 64'd1);
    chk("add result", 64'(result), 64'd4);
    chk("add zero", 64'(zero), 64'd0);
    drive(R, 3'd0, F7A, 32'd5, 32'd5);
    chk("b2b in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("sub valid", 64'(out_valid), 64'd1);
    chk("sub result", 64'(result), 64'd0);
    chk("sub zero", 64'(zero), 64'd1);
    tick();
    chk("drop valid", 64'(out_valid), 64'd0);

    // shifts, compares, decode corners
    run("sra",   R, 3'd5, F7A, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 1'b0);
    run("srai",  I, 3'd5, F7A, 32'h8000_0000, 32'd4, 32'hF800_0000, 1, 1'b0);
    run("srli",  I, 3'd5, F7B, 32'h8000_0000, 32'd4, 32'h0800_0000, 1, 1'b0);
    run("sltu",  R, 3'd3, F7B, 32'd1, 32'hFFFF_FFFF, 32'd1, 1, 1'b0);
    run("slt",   R, 3'd2, F7B, 32'd1, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    run("sll5b", R, 3'd1, F7B, 32'd1, 32'h21, 32'd2, 1, 1'b0);
    run("xori",  I, 3'd4, 7'h55, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1, 1'b0);
    run("ldst",  OPA, 3'd2, 7'h7F, 32'd100, 32'hFFFF_FFFC, 32'd96, 1, 1'b0);
    run("br",    OPB, 3'd0, 7'h00, 32'd9, 32'd9, 32'd0, 1, 1'b0);
    run("slli1", I, 3'd1, F7A, 32'd1, 32'd1, 32'd0, 1, 1'b1);
    run("mulh",  R, 3'd1, F7M, 32'd3, 32'd3, 32'd0, 1, 1'b1);
    run("badf7", R, 3'd0, 7'h10, 32'd3, 32'd3, 32'd0, 1, 1'b1);

    // M-extension
    run("mul",    R, 3'd0, F7M, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 34, 1'b0);
    run("div",    R, 3'd4, F7M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
    run("rem",    R, 3'd6, F7M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
    run("divu",   R, 3'd5, F7M, 32'd100, 32'd7, 32'd14, 34, 1'b0);
    run("remu",   R, 3'd7, F7M, 32'd100, 32'd7, 32'd2, 34, 1'b0);
    run("divu0",  R, 3'd5, F7M, 32'd10, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run("remu0",  R, 3'd7, F7M, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run("removf", R, 3'd6, F7M, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    run("divovf", R, 3'd4, F7M, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);

    // reset in the middle of a DIV
    tick();
    drive(R, 3'd4, F7M, 32'd1000, 32'd3);
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("rst busy valid", 64'(out_valid), 64'd0);
    chk("rst busy in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0; #1;
    chk("rst busy ready after", 64'(in_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
    chk("rst busy no result", 64'(seen), 64'd0);

    // held result under backpressure
    out_ready = 1'b0;
    drive(R, 3'd0, F7B, 32'd3, 32'd4);
    tick();
    chk("hold first", 64'(result), 64'd7);
    drive(R, 3'd0, F7A, 32'd1, 32'd1);
    ok = 1'b1;
    repeat (3) begin
      tick();
      if (!out_valid || result != 32'd7 || zero || illegal || in_ready) ok = 1'b0;
    end
    chk("hold stable", 64'(ok), 64'd1);
    out_ready = 1'b1; #1;
    chk("hold release ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("after hold result", 64'(result), 64'd0);
    chk("after hold zero", 64'(zero), 64'd1);
    tick();
    chk("after hold drop", 64'(out_valid), 64'd0);

    // flush during BUSY, then flush with an op offered
    drive(R, 3'd0, F7M, 32'd5, 32'd6);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin tick(); if (out_valid) seen = 1'b1; end
    chk("flush busy no result", 64'(seen), 64'd0);
    drive(R, 3'd0, F7B, 32'd1, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush drops op", 64'(out_valid), 64'd0);
    run("post flush", R, 3'd0, F7B, 32'd2, 32'd2, 32'd4, 1, 1'b0);
    run("post flush mul", R, 3'd0, F7M, 32'd6, 32'd7, 32'd42, 34, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
